// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo-N counter: end-of-range mode encodings
// and the modulus legality test used when a new modulus is written.
package mod_counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // A modulus is usable when the count register can hold every value 0..mod-1.
   function automatic logic valid_mod(input logic [31:0] mod, input int unsigned width);
      return (mod >= 32'd2) && (mod <= (32'd1 << width));
   endfunction

endpackage

// File: rtl/mod_shadow_reg.sv
// Modulus holding register with a shadow copy: writes are validated and parked
// until the counter core signals a safe point (roll-over, end hold or load).
module mod_shadow_reg
   import mod_counter_pkg::*;
#(
   parameter int WIDTH       = 3,
   parameter int DEFAULT_MOD = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mod_wr,
   input  logic [WIDTH:0]   mod_val,
   input  logic             apply,
   output logic [WIDTH:0]   mod_active,
   output logic [WIDTH:0]   mod_new,
   output logic             mod_err
);

   localparam logic [WIDTH:0] DEF_MOD = DEFAULT_MOD[WIDTH:0];

   logic [WIDTH:0] shadow_reg;
   logic           pend_reg;
   logic           wr_ok;

   assign wr_ok   = valid_mod(32'(mod_val), WIDTH);
   // Modulus that will be in force after an apply this cycle.
   assign mod_new = pend_reg ? shadow_reg : mod_active;

   always_ff @(posedge clk) begin
      if (rst) begin
         mod_active <= DEF_MOD;
         shadow_reg <= '0;
         pend_reg   <= 1'b0;
         mod_err    <= 1'b0;
      end else begin
         mod_err <= mod_wr & ~wr_ok;
         if (apply && pend_reg) begin
            mod_active <= shadow_reg;
            pend_reg   <= 1'b0;
         end
         // A write coinciding with an apply is kept for the next one.
         if (mod_wr && wr_ok) begin
            shadow_reg <= mod_val;
            pend_reg   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mod_n_counter.sv
// Programmable modulo-N up/down counter with load, wrap-or-saturate end
// behaviour and strobes for cascading.
module mod_n_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH       = 3,
   parameter int DEFAULT_MOD = 5,
   parameter int SATURATE    = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mod_wr,
   input  logic [WIDTH:0]   mod_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH:0]   mod_active,
   output logic             tc,
   output logic             wrap,
   output logic             sat,
   output logic             mod_err
);

   localparam logic MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

   logic [WIDTH:0]   mod_new;
   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   last_cur;
   logic [WIDTH:0]   last_new;
   logic [WIDTH-1:0] load_clamp;
   logic [WIDTH-1:0] hold_clamp;
   logic             at_top;
   logic             at_bot;
   logic             apply;

   assign cnt_ext  = {1'b0, count};
   assign last_cur = mod_active - 1'b1;
   assign last_new = mod_new - 1'b1;
   assign at_top   = (cnt_ext == last_cur);
   assign at_bot   = (count == '0);
   assign tc       = en & (up_dn ? at_top : at_bot);

   // Every place the modulus may change: a load, or an enabled edge at the end.
   assign apply = load | tc;

   assign load_clamp = ({1'b0, load_val} > last_new) ? last_new[WIDTH-1:0] : load_val;
   assign hold_clamp = (cnt_ext > last_new) ? last_new[WIDTH-1:0] : count;

   mod_shadow_reg #(
      .WIDTH       (WIDTH),
      .DEFAULT_MOD (DEFAULT_MOD)
   ) u_shadow (
      .clk        (clk),
      .rst        (rst),
      .mod_wr     (mod_wr),
      .mod_val    (mod_val),
      .apply      (apply),
      .mod_active (mod_active),
      .mod_new    (mod_new),
      .mod_err    (mod_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
         sat   <= 1'b0;
      end else if (load) begin
         count <= load_clamp;
         wrap  <= 1'b0;
         sat   <= 1'b0;
      end else if (en) begin
         if (tc) begin
            if (MODE == MODE_WRAP) begin
               count <= up_dn ? '0 : last_new[WIDTH-1:0];
               wrap  <= 1'b1;
               sat   <= 1'b0;
            end else begin
               // Holding; a newly applied larger modulus lets an up count resume.
               count <= hold_clamp;
               wrap  <= 1'b0;
               sat   <= up_dn ? (cnt_ext >= last_new) : 1'b1;
            end
         end else begin
            count <= up_dn ? count + 1'b1 : count - 1'b1;
            wrap  <= 1'b0;
            sat   <= 1'b0;
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mod_n_counter.sv
// Drives a wrapping and a saturating counter with the same directed and
// random stimulus and compares both against a range-based reference model.
module tb_mod_n_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, up_dn = 1'b1, load = 1'b0, mod_wr = 1'b0;
   logic [2:0] load_val = '0;
   logic [3:0] mod_val = '0;

   logic [2:0] count_w, count_s;
   logic [3:0] mod_w, mod_s;
   logic       tc_w, tc_s, wrap_w, wrap_s, sat_w, sat_s, err_w, err_s;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cyc    = 0;
   bit armed    = 1'b0;

   // Reference model state, index 0 = wrapping, 1 = saturating.
   int m_cnt[2], m_mod[2], m_sh[2], m_pend[2], m_wrap[2], m_sat[2], m_err[2];

   always #5 clk = ~clk;

   mod_n_counter #(.WIDTH(3), .DEFAULT_MOD(5), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .mod_wr(mod_wr), .mod_val(mod_val), .count(count_w), .mod_active(mod_w),
      .tc(tc_w), .wrap(wrap_w), .sat(sat_w), .mod_err(err_w)
   );

   mod_n_counter #(.WIDTH(3), .DEFAULT_MOD(5), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .mod_wr(mod_wr), .mod_val(mod_val), .count(count_s), .mod_active(mod_s),
      .tc(tc_s), .wrap(wrap_s), .sat(sat_s), .mod_err(err_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, n_cyc, obs, exp);
      end
   endtask

   task automatic model_reset(input int k);
      m_cnt[k] = 0; m_mod[k] = 5; m_sh[k] = 0; m_pend[k] = 0;
      m_wrap[k] = 0; m_sat[k] = 0; m_err[k] = 0;
   endtask

   // One clock edge of the specified behaviour, in terms of the target count
   // leaving the legal range 0..mod-1.
   task automatic model_step(input int k);
      int  nm, tgt;
      bit  applied, ok;
      if (rst) begin
         model_reset(k);
         return;
      end
      nm      = (m_pend[k] != 0) ? m_sh[k] : m_mod[k];
      applied = 1'b0;
      ok      = (mod_val >= 2) && (mod_val <= 8);
      if (load) begin
         m_cnt[k]  = (int'(load_val) < nm - 1) ? int'(load_val) : nm - 1;
         m_wrap[k] = 0;
         m_sat[k]  = 0;
         applied   = 1'b1;
      end else if (en) begin
         tgt = up_dn ? m_cnt[k] + 1 : m_cnt[k] - 1;
         if (tgt >= 0 && tgt < m_mod[k]) begin
            m_cnt[k] = tgt; m_wrap[k] = 0; m_sat[k] = 0;
         end else begin
            applied = 1'b1;
            if (k == 0) begin
               m_cnt[k] = up_dn ? 0 : nm - 1;
               m_wrap[k] = 1; m_sat[k] = 0;
            end else begin
               if (m_cnt[k] > nm - 1) m_cnt[k] = nm - 1;
               m_wrap[k] = 0;
               m_sat[k]  = up_dn ? int'(m_cnt[k] == nm - 1) : 1;
            end
         end
      end else begin
         m_wrap[k] = 0;
      end
      if (applied && m_pend[k] != 0) begin
         m_mod[k] = m_sh[k]; m_pend[k] = 0;
      end
      m_err[k] = (mod_wr && !ok) ? 1 : 0;
      if (mod_wr && ok) begin
         m_sh[k] = int'(mod_val); m_pend[k] = 1;
      end
   endtask

   function automatic int model_tc(input int k);
      if (!en) return 0;
      return up_dn ? int'(m_cnt[k] == m_mod[k] - 1) : int'(m_cnt[k] == 0);
   endfunction

   task automatic compare_all();
      check("count_w", 32'(count_w), m_cnt[0]);
      check("mod_w",   32'(mod_w),   m_mod[0]);
      check("tc_w",    32'(tc_w),    model_tc(0));
      check("wrap_w",  32'(wrap_w),  m_wrap[0]);
      check("sat_w",   32'(sat_w),   m_sat[0]);
      check("err_w",   32'(err_w),   m_err[0]);
      check("count_s", 32'(count_s), m_cnt[1]);
      check("mod_s",   32'(mod_s),   m_mod[1]);
      check("tc_s",    32'(tc_s),    model_tc(1));
      check("wrap_s",  32'(wrap_s),  m_wrap[1]);
      check("sat_s",   32'(sat_s),   m_sat[1]);
      check("err_s",   32'(err_s),   m_err[1]);
   endtask

   task automatic cycle(input bit r, input bit e, input bit ud, input bit ld, input int lv,
                        input bit mw, input int mv);
      logic [31:0] lv_v, mv_v;
      lv_v = lv;
      mv_v = mv;
      @(negedge clk);
      rst = r; en = e; up_dn = ud; load = ld; load_val = lv_v[2:0];
      mod_wr = mw; mod_val = mv_v[3:0];
      #1;
      if (armed) compare_all();
      $display("cyc %0d rst=%0d en=%0d ud=%0d ld=%0d/%0d wr=%0d/%0d | w: cnt=%0d mod=%0d tc=%0d wrap=%0d | s: cnt=%0d mod=%0d tc=%0d sat=%0d",
               n_cyc, r, e, ud, ld, lv, mw, mv, count_w, mod_w, tc_w, wrap_w,
               count_s, mod_s, tc_s, sat_s);
      @(posedge clk);
      model_step(0);
      model_step(1);
      n_cyc++;
      if (r) armed = 1'b1;
   endtask

   initial begin
      model_reset(0);
      model_reset(1);

      cycle(1, 0, 1, 0, 0, 0, 0);
      cycle(1, 0, 1, 0, 0, 0, 0);

      // Legacy mod-5 sequence.
      for (int i = 0; i < 12; i++) begin
         cycle(0, 1, 1, 0, 0, 0, 0);
         #1 check("legacy_seq", 32'(count_w), (i + 1) % 5);
      end

      // Down count from 2: 1,0,4,3.
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0, 0);

      // Modulus 7 written mid-sequence, applied at the next roll-over.
      cycle(0, 1, 1, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 1, 7);
      for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0, 0, 0, 0);

      // Illegal moduli and a last-write-wins pair.
      cycle(0, 1, 1, 0, 0, 1, 1);
      cycle(0, 1, 1, 0, 0, 1, 9);
      cycle(0, 0, 1, 0, 0, 1, 3);
      cycle(0, 0, 1, 0, 0, 1, 5);

      // Load applies the pending modulus and clamps; load beats en; rst beats load.
      cycle(0, 0, 1, 1, 6, 0, 0);
      cycle(0, 1, 1, 1, 2, 0, 0);
      cycle(0, 1, 1, 1, 3, 0, 0);
      cycle(1, 1, 1, 1, 3, 0, 0);

      // Saturation at the top, then release downward.
      for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0, 0);

      // en toggled around count=4.
      cycle(0, 0, 1, 1, 4, 0, 0);
      cycle(0, 1, 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 0, 0, 0);

      // Full-range modulus, then randomized traffic.
      cycle(0, 1, 1, 0, 0, 1, 8);
      for (int i = 0; i < 800; i++) begin
         cycle($urandom_range(0, 99) < 2,
               $urandom_range(0, 99) < 80,
               $urandom_range(0, 99) < 60,
               $urandom_range(0, 99) < 6,
               $urandom_range(0, 7),
               $urandom_range(0, 99) < 8,
               $urandom_range(0, 10));
      end
      cycle(0, 0, 1, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
Parametrised modulo-N counter, successor to the fixed mod-5 counter. Adds a runtime-programmable modulus with glitch-free shadow update, up/down direction, count enable, synchronous load, wrap-or-saturate mode, and terminal-count/wrap strobes for cascading. It is used as a timebase and sequence-index generator in interview and teaching designs. With default parameters and en=1, up_dn=1, it matches the legacy mod-5 sequence 0,1,2,3,4,0.

Parameters:
- WIDTH, 3, count register width in bits.
- DEFAULT_MOD, 5, modulus after reset; must satisfy 2 <= DEFAULT_MOD <= 2^WIDTH.
- SATURATE, 0, selects end-of-range behaviour: 0 = wrap, 1 = hold at the end value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- mod_wr  in  1  modulus write strobe.
- mod_val  in  WIDTH+1  new modulus.
- count  out  WIDTH  current count.
- mod_active  out  WIDTH+1  modulus currently in effect.
- tc  out  1  terminal count, combinational.
- wrap  out  1  registered one-cycle wrap strobe.
- sat  out  1  registered flag: counter is held at its end value.
- mod_err  out  1  registered one-cycle strobe: rejected modulus write.

Behaviour:
Reset
- Reset is synchronous, active-high, with clock clk.
- On rst: count=0, mod_active=DEFAULT_MOD, shadow=0, pend=0, wrap=0, sat=0, mod_err=0.
- rst has priority over every other input.

Terminal count
- tc = en & (up_dn ? count==mod_active-1 : count==0).

Priority per cycle
- rst, then load, then en.

Load
- When load=1, count <= min(load_val, mod_active-1).
- If pend=1, mod_active <= shadow and pend clears. The clamp then uses the new modulus.
- wrap=0 and sat=0 after a load.

Count, SATURATE=0
- up: count <= (count==mod_active-1) ? 0 : count+1.
- down: count <= (count==0) ? mod_active-1 : count-1.
- wrap=1 in the cycle after the roll-over edge.

Count, SATURATE=1
- At the end value the count holds; wrap stays 0; sat=1 while holding.
- sat clears on load, or on a count step in the opposite direction.

en=0
- Count holds; wrap=0.

Modulus write
- mod_wr accepted when 2 <= mod_val <= 2^WIDTH: shadow <= mod_val, pend <= 1.
- Otherwise the write is ignored and mod_err=1 for one cycle.
- A pending modulus is applied at the next roll-over edge: the count goes to 0 (up) or to new_mod-1 (down), together with mod_active <= shadow. It is also applied by a load.
- In SATURATE=1 the pending modulus is applied on the first enabled cycle while holding at the end. The count is re-clamped to new_mod-1 if needed.
- A write in the same cycle as the roll-over is not used for that roll-over; it becomes pending.
- A second write while pending overwrites shadow (last write wins).

Boundaries
- Direction change mid-sequence takes effect on the next enabled edge.
- mod_active = 2^WIDTH: the count uses its full range, and roll-over wraps naturally.
- Reset mid-sequence discards pend.

Latency
- count, wrap and sat update 1 cycle after the inputs are sampled.
- tc is 0-cycle (combinational).

Decomposition:
- Shared package mod_counter_pkg holds:
  - function valid_mod(mod, width);
  - localparam encodings MODE_WRAP=0 and MODE_SAT=1.
- One sub-module is natural: mod_shadow_reg. It owns mod_active, shadow, pend, validation and mod_err, and takes an apply strobe from the counter core.

Test Plan:
- Defaults, rst high for 2 cycles then low, en=1, up_dn=1 for 12 cycles -> count 0,1,2,3,4,0,1,...; tc high when count=4; wrap high on each cycle where count=0 following 4.
- Down count, up_dn=0 from count=2 -> 1,0,4,3; tc at 0; wrap after the 0 to 4 edge.
- mod_wr with mod_val=7 at count=1 -> mod_active stays 5 until the wrap; the next cycle runs 0..6; mod_wr with mod_val=1 or mod_val=9 (WIDTH=3) -> mod_err pulses, mod_active unchanged.
- load with load_val=6 while mod_active=5 -> count=4; load and en in the same cycle -> load wins; rst together with load -> count=0.
- SATURATE=1, mod 5, up -> count holds at 4 with sat=1 and wrap never asserted; up_dn=0 -> count=3 and sat=0.
- en toggled 1,0,0,1 around count=4 -> count holds while en=0 and tc=0 during the hold; wrap fires only after the enabled edge.
